// File: rtl/pattern_pkg.sv
// Shared types for the test-pattern sequencer: pattern indices and debounce FSM states.
package pattern_pkg;

  localparam int unsigned PATTERN_W  = 4;
  localparam int unsigned DBNC_CNT_W = 20;
  localparam int unsigned FC_W       = 8;

  typedef enum logic [PATTERN_W-1:0] {
    PatBlack,
    PatWhite,
    PatRed,
    PatGreen,
    PatBlue,
    PatGridS,
    PatGridL,
    PatHgrad,
    PatVgrad,
    PatHgradR,
    PatHgradG,
    PatHgradB,
    PatBars,
    PatXor
  } pattern_e;

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } dbnc_state_e;

  function automatic logic [PATTERN_W-1:0] next_pattern(input logic [PATTERN_W-1:0] sel,
                                                        input logic [PATTERN_W-1:0] last);
    return (sel == last) ? '0 : sel + 1'b1;
  endfunction

endpackage

// File: rtl/key_debouncer.sv
// Synchronises the raw key and emits one press pulse per debounced press; holding or
// bouncing on release never produces another pulse.
module key_debouncer
  import pattern_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_pixel,
  input  logic rst,
  input  logic key,
  output logic press
);

  localparam logic [DBNC_CNT_W-1:0] CntLast = DBNC_CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > (1 << DBNC_CNT_W)) begin : g_bad_dbnc
    $error("DEBOUNCE_CYCLES out of range");
  end

  logic                  key_meta_q;
  logic                  key_s_q;
  dbnc_state_e           state_q;
  logic [DBNC_CNT_W-1:0] cnt_q;
  logic                  press_q;

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      key_meta_q <= 1'b0;
      key_s_q    <= 1'b0;
    end else begin
      key_meta_q <= key;
      key_s_q    <= key_meta_q;
    end
  end

  // cnt restarts on every state change so each wait measures an unbroken stable run.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      press_q <= 1'b0;
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (key_s_q) begin
            state_q <= StPressWait;
          end
        end
        StPressWait: begin
          if (!key_s_q) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StPressed;
            cnt_q   <= '0;
            press_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StPressed: begin
          cnt_q <= '0;
          if (!key_s_q) begin
            state_q <= StReleaseWait;
          end
        end
        StReleaseWait: begin
          if (key_s_q) begin
            state_q <= StPressed;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= StIdle;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign press = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Turns debounced key presses into pattern advances applied only at frame start.
// Define PATTERN_AUTOCYCLE_EN to add the auto_en port and timed auto-cycling.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int unsigned NUM_PATTERNS    = 14,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned AUTO_FRAMES     = 120
) (
  input  logic                 clk_pixel,
  input  logic                 rst,
  input  logic                 key,
  input  logic [9:0]           cx,
  input  logic [9:0]           cy,
`ifdef PATTERN_AUTOCYCLE_EN
  input  logic                 auto_en,
`endif
  output logic [PATTERN_W-1:0] pattern_sel,
  output logic                 pattern_changed
);

  localparam logic [PATTERN_W-1:0] SelLast = PATTERN_W'(NUM_PATTERNS - 1);

  if (NUM_PATTERNS < 2 || NUM_PATTERNS > (1 << PATTERN_W)) begin : g_bad_num
    $error("NUM_PATTERNS out of range");
  end

  logic press;

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debouncer (
    .clk_pixel(clk_pixel),
    .rst      (rst),
    .key      (key),
    .press    (press)
  );

  // Frame start is the registered rising edge of the origin, so a raster that lingers
  // at (0,0) still yields a single pulse.
  logic origin;
  logic origin_q;
  logic frame_start_q;

  assign origin = (cx == '0) && (cy == '0);

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      origin_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      origin_q      <= origin;
      frame_start_q <= origin & ~origin_q;
    end
  end

  logic auto_hit;
  logic advance;
  logic pending_q;
  logic [PATTERN_W-1:0] sel_q;
  logic changed_q;

`ifdef PATTERN_AUTOCYCLE_EN
  localparam logic [FC_W-1:0] FcLast = FC_W'(AUTO_FRAMES - 1);

  if (AUTO_FRAMES < 1 || AUTO_FRAMES > (1 << FC_W)) begin : g_bad_auto
    $error("AUTO_FRAMES out of range");
  end

  logic [FC_W-1:0] fc_q;

  assign auto_hit = auto_en && (fc_q == FcLast);

  // Any advance restarts the frame count so auto-cycling never fires right after a
  // manual step.
  always_ff @(posedge clk_pixel) begin
    if (rst || !auto_en) begin
      fc_q <= '0;
    end else if (advance) begin
      fc_q <= '0;
    end else if (frame_start_q) begin
      fc_q <= fc_q + 1'b1;
    end
  end
`else
  assign auto_hit = 1'b0;
`endif

  assign advance = frame_start_q & (pending_q | press | auto_hit);

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      pending_q <= 1'b0;
      sel_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      changed_q <= advance;
      if (advance) begin
        pending_q <= 1'b0;
        sel_q     <= next_pattern(sel_q, SelLast);
      end else if (press) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign pattern_sel     = sel_q;
  assign pattern_changed = changed_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer on a 20x10 raster with a short debounce window.
module tb_pattern_sequencer;

  logic       clk_pixel = 1'b0;
  logic       rst;
  logic       key;
  logic [9:0] cx;
  logic [9:0] cy;
`ifdef PATTERN_AUTOCYCLE_EN
  logic       auto_en;
`endif
  logic [3:0] pattern_sel;
  logic       pattern_changed;

  int n_checks = 0;
  int n_pass   = 0;
  int sel_steps = 0;
  int chg_hi    = 0;
  int bad_pos   = 0;
  int mism      = 0;

  always #5 clk_pixel = ~clk_pixel;

  pattern_sequencer #(
    .NUM_PATTERNS   (14),
    .DEBOUNCE_CYCLES(4),
    .AUTO_FRAMES    (3)
  ) dut (
    .clk_pixel      (clk_pixel),
    .rst            (rst),
    .key            (key),
    .cx             (cx),
    .cy             (cy),
`ifdef PATTERN_AUTOCYCLE_EN
    .auto_en        (auto_en),
`endif
    .pattern_sel    (pattern_sel),
    .pattern_changed(pattern_changed)
  );

  task automatic check(input string tag, input logic [31:0] got, input int exp);
    n_checks++;
    if (got === 32'(exp)) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // Raster generator plus pulse monitor; a step must appear one cycle after the origin.
  initial begin
    logic [3:0] prev;
    prev = '0;
    cx = '0;
    cy = '0;
    forever begin
      @(negedge clk_pixel);
      if (rst !== 1'b0) begin
        prev = pattern_sel;
      end else begin
        if (pattern_changed === 1'b1) chg_hi++;
        if (pattern_sel !== prev) begin
          sel_steps++;
          if (!(cx == 10'd1 && cy == 10'd0)) bad_pos++;
        end
        if (pattern_changed !== (pattern_sel !== prev)) mism++;
        prev = pattern_sel;
      end
      if (cx == 10'd19) begin
        cx = '0;
        cy = (cy == 10'd9) ? 10'd0 : cy + 10'd1;
      end else begin
        cx = cx + 10'd1;
      end
    end
  end

  task automatic wait_pos(input int x, input int y);
    int n;
    n = 0;
    do begin
      @(posedge clk_pixel);
      n++;
    end while (!(cx == 10'(x) && cy == 10'(y)) && n < 500);
    if (n >= 500) check("wait_timeout", n, 0);
  endtask

  task automatic hold_key(input int n);
    @(negedge clk_pixel);
    key = 1'b1;
    repeat (n) @(negedge clk_pixel);
    key = 1'b0;
  endtask

  task automatic press_next_frame;
    hold_key(10);
    wait_pos(5, 0);
    @(negedge clk_pixel);
  endtask

  task automatic do_reset;
    @(negedge clk_pixel);
    rst = 1'b1;
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    key = 1'b1;
`ifdef PATTERN_AUTOCYCLE_EN
    auto_en = 1'b0;
`endif
    // 1: reset state, key held through reset counts as one fresh press
    repeat (3) @(posedge clk_pixel);
    @(negedge clk_pixel);
    check("reset_sel", pattern_sel, 0);
    check("reset_changed", pattern_changed, 0);
    rst = 1'b0;
    repeat (20) @(negedge clk_pixel);
    key = 1'b0;
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("key_through_reset", pattern_sel, 1);

    // 2: short glitch ignored, real press advances at the next frame
    hold_key(3);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("glitch_no_advance", pattern_sel, 1);
    hold_key(20);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("press_advance", pattern_sel, 2);

    // 3: two presses within one frame give one advance
    hold_key(10);
    repeat (12) @(negedge clk_pixel);
    hold_key(10);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("double_press_one_step", pattern_sel, 3);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("double_press_dropped", pattern_sel, 3);

    // 4: press pulse lands exactly in the frame_start cycle
    wait_pos(13, 9);
    hold_key(12);
    wait_pos(10, 0);
    @(negedge clk_pixel);
    check("press_at_frame_start", pattern_sel, 4);
    wait_pos(10, 0);
    @(negedge clk_pixel);
    check("no_leftover_pending", pattern_sel, 4);
    for (int i = 0; i < 9; i++) press_next_frame();
    check("reach_last", pattern_sel, 13);
    press_next_frame();
    check("wrap_to_zero", pattern_sel, 0);

    // 5: long hold is one press; release bounce adds nothing
    @(negedge clk_pixel);
    key = 1'b1;
    repeat (5) wait_pos(5, 0);
    @(negedge clk_pixel);
    check("hold_single_advance", pattern_sel, 1);
    key = 1'b0;
    repeat (2) @(negedge clk_pixel);
    key = 1'b1;
    repeat (4) @(negedge clk_pixel);
    key = 1'b0;
    wait_pos(5, 0);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("release_bounce", pattern_sel, 1);

`ifdef PATTERN_AUTOCYCLE_EN
    // 6: auto-cycle every 3 frames; a manual step restarts the count
    do_reset();
    wait_pos(5, 0);
    @(negedge clk_pixel);
    auto_en = 1'b1;
    wait_pos(5, 0);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("auto_f2", pattern_sel, 0);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("auto_f3", pattern_sel, 1);
    wait_pos(5, 0);
    wait_pos(5, 0);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("auto_f6", pattern_sel, 2);
    wait_pos(5, 0);
    press_next_frame();
    check("auto_manual_f8", pattern_sel, 3);
    wait_pos(5, 0);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("auto_fc_restart_f10", pattern_sel, 3);
    wait_pos(5, 0);
    @(negedge clk_pixel);
    check("auto_f11", pattern_sel, 4);
    auto_en = 1'b0;
`endif

    repeat (5) @(negedge clk_pixel);
    check("changed_width", chg_hi, sel_steps);
    check("changed_vs_sel", mism, 0);
    check("step_position", bad_pos, 0);
`ifdef PATTERN_AUTOCYCLE_EN
    check("total_steps", sel_steps, 19);
`else
    check("total_steps", sel_steps, 15);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
